lfsr_prng: RTL

//  Parametrised Fibonacci XNOR LFSR pseudo-random source for NoC traffic generators and FIFO test harnesses.

---
 rtl/lfsr_prng_if.sv | 27 ++
 rtl/lfsr_prng.sv | 96 +++++++++
 2 files changed

// File: rtl/lfsr_prng_if.sv
// Handshake bundle between an LFSR pseudo-random source and its consumer.
//   en, load, seed, rnd_ready : consumer -> generator
//   rnd_valid, rnd_data       : generator -> consumer (valid/ready stream)
//   wrap, lockup              : generator status flags
// master = consumer side, slave = generator side.
interface lfsr_prng_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             rnd_ready;
  logic             rnd_valid;
  logic [WIDTH-1:0] rnd_data;
  logic             wrap;
  logic             lockup;

  modport master (
    output en, load, seed, rnd_ready,
    input  rnd_valid, rnd_data, wrap, lockup
  );

  modport slave (
    input  en, load, seed, rnd_ready,
    output rnd_valid, rnd_data, wrap, lockup
  );
endinterface

// File: rtl/lfsr_prng.sv
// Fibonacci XNOR LFSR pseudo-random source with valid/ready output.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset (state returns to SEED)
//   bus  : lfsr_prng_if.slave
//          en        - enables rnd_valid
//          load/seed - run-time seed install (all-ones seed is rejected)
//          rnd_ready - consumer accepts rnd_data; state advances on valid&ready
//          rnd_valid - valid_q & en & ~load
//          rnd_data  - registered LFSR state
//          wrap      - 1-cycle pulse when the step returns to the start value
//          lockup    - sticky: all-ones state seen or requested
module lfsr_prng #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1001),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_prng_if.slave   bus
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be 3..32");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_prng: TAPS[WIDTH-1] must be set");
  end
  if (&SEED) begin : g_bad_seed
    $error("lfsr_prng: SEED must not be all-ones");
  end

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] start_q,  start_d;
  logic             valid_q,  valid_d;
  logic             wrap_q,   wrap_d;
  logic             lockup_q, lockup_d;

  logic             fb;
  logic [WIDTH-1:0] step;
  logic             advance;

  // All-ones is the XNOR lock-up state: it maps onto itself, so it is
  // never installed and is recovered to zero if it ever appears.
  always_comb begin
    fb       = ~^(state_q & TAPS);
    step     = {state_q[WIDTH-2:0], fb};
    advance  = bus.rnd_valid & bus.rnd_ready;

    state_d  = state_q;
    start_d  = start_q;
    lockup_d = lockup_q;
    wrap_d   = 1'b0;
    valid_d  = 1'b1;

    if (bus.load) begin
      if (&bus.seed) begin
        state_d  = '0;
        start_d  = '0;
        lockup_d = 1'b1;
      end else begin
        state_d  = bus.seed;
        start_d  = bus.seed;
        lockup_d = 1'b0;
      end
    end else if (&state_q) begin
      state_d  = '0;
      lockup_d = 1'b1;
    end else if (advance) begin
      state_d = step;
      wrap_d  = (step == start_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEED;
      start_q  <= SEED;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.rnd_valid = valid_q & bus.en & ~bus.load;
  assign bus.rnd_data  = state_q;
  assign bus.wrap      = wrap_q;
  assign bus.lockup    = lockup_q;

endmodule
